asin_unit_scheduler: RTL
========================

Name: asin_unit_scheduler

Overview:
- Shares one multi-cycle fixed-point arcsine unit (the angle unit behind the navigation/arm trig path) between NREQ requesters, e.g. nav heading, arm shoulder, arm elbow, arm wrist.
- Arbitrates round-robin and range-checks the argument before issue.
- Sequences start/done with the unit, applies a timeout, and returns a tagged result to the winning requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- XW, 16, argument width, signed Q2.14 (+1.0 = 16'h4000).
- TW, 16, theta width, signed Q3.13 radians.
- TIMEOUT, 64, maximum WAIT cycles before the operation is abandoned (≥2).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request; held high with req_x stable until ack.
- req_x  in  NREQ*XW  packed arguments; requester i at bits [i*XW +: XW].
- ack  out  NREQ  one-hot, one-cycle pulse when request i is accepted.
- resp_valid  out  1  one-cycle result strobe.
- resp_id  out  3  index of the requester owning the result.
- resp_theta  out  TW  result angle.
- resp_err  out  1  1 = domain error or timeout; resp_theta = 0.
- unit_start  out  1  one-cycle start pulse to the arcsine unit.
- unit_x  out  XW  argument to the unit, held from start until the next grant.
- unit_done  in  1  unit completion pulse.
- unit_theta  in  TW  unit result, valid with unit_done.

Behaviour:
- Reset (synchronous, RST high at a clock edge):
  - State = IDLE; rr_ptr = 0.
  - ack, resp_valid, resp_err, unit_start = 0; resp_id, resp_theta, unit_x = 0; timeout counter = 0.
  - Any in-flight operation is dropped with no response. A unit_done that arrives after reset is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Scans req_valid starting at rr_ptr, wrapping modulo NREQ; the first set bit wins (index g).
  - Latches g and req_x[g] into internal registers.
  - If |x| ≤ 16'h4000: next state = ISSUE.
  - If x > 16'h4000 or x < 16'hC000 (domain error): next state = RESP with err flag set.
  - rr_ptr ← (g+1) mod NREQ on any grant.
  - With no req_valid set, stays in IDLE.
- ISSUE (1 cycle):
  - unit_start = 1, unit_x = latched x, ack[g] = 1.
  - Clears the timeout counter; next state = WAIT.
- Domain-error path:
  - ack[g] = 1 in the same cycle as resp_valid (the RESP cycle).
  - The unit is never started.
- WAIT:
  - Counter increments every cycle.
  - On unit_done = 1: capture unit_theta; next state = RESP with err = 0.
  - If the counter reaches TIMEOUT-1 without unit_done: next state = RESP with err = 1, theta = 0.
  - If unit_done and the timeout coincide, done wins.
- RESP (1 cycle):
  - resp_valid = 1, resp_id = g, resp_theta and resp_err per the captured values.
  - Next state = IDLE; a new grant can be sampled the cycle after RESP.
- Outputs between RESP strobes:
  - resp_id, resp_theta and resp_err hold their last values.
  - resp_valid and ack are low outside the cycles defined above.
- Latency: request sampled in IDLE at cycle t gives ack/unit_start at t+1. A unit_done at cycle d gives resp_valid at d+1. Minimum issue-to-response time = 3 cycles plus unit latency.
- Ignored or tolerated events:
  - unit_done outside WAIT (including the ISSUE cycle and late arrivals after a timeout) is ignored.
  - A requester dropping req_valid before its ack is legal; it simply loses that arbitration.
  - A requester holding req_valid after ack is treated as a new request.
- Fairness: with all NREQ requesting continuously, each is served exactly once per NREQ operations.
- Values x = ±16'h4000 exactly are legal (not domain errors).

Test Plan:
- Reset then req_valid=4'b0001, x=16'h2000 (0.5); unit answers done after 5 cycles with theta=16'h10C1 → ack[0] one cycle after request, unit_start same cycle, resp_valid with id=0, theta=16'h10C1, err=0 one cycle after done.
- All four requesting continuously, unit latency 3 → grant order 0,1,2,3,0,1; each ack one-hot; no requester served twice before all served once.
- req_valid[2]=1, x=16'h4001 → no unit_start; ack[2] and resp_valid same cycle, id=2, err=1, theta=0. x=16'h4000 and x=16'hC000 → unit_start issued, err=0.
- Unit never asserts done, TIMEOUT=64 → resp_valid with err=1, theta=0 exactly 64 cycles after WAIT entry. A unit_done pulse 3 cycles later is ignored (no second resp_valid).
- RST asserted for 1 cycle during WAIT, then unit_done arrives → no resp_valid; all outputs 0 after the reset edge. Next grant starts from requester 0.
- unit_done coincident with the timeout cycle → resp_err=0 and resp_theta = unit_theta.

Source files
------------

// File: rtl/asin_unit_scheduler.sv
// ---------------------------------------------------------------------------
// asin_unit_scheduler
//
// Shares one multi-cycle fixed-point arcsine unit between NREQ requesters.
// A round-robin arbiter picks one pending request. Its argument is
// range-checked before the unit is started. The scheduler then waits for the
// unit, with a timeout, and returns a tagged result to the winner.
//
// Ports
//   CLK          system clock, rising edge
//   RST          synchronous active-high reset
//   req_valid    per-requester request, held with req_x stable until ack
//   req_x        packed Q2.14 arguments, requester i at [i*XW +: XW]
//   ack          one-hot accept pulse
//   resp_valid   one-cycle result strobe
//   resp_id      requester that owns the result (held between strobes)
//   resp_theta   Q3.13 result angle (held between strobes)
//   resp_err     domain error or timeout, theta forced to 0 (held)
//   unit_start   one-cycle start pulse to the arcsine unit
//   unit_x       unit argument, held from start until the next grant
//   unit_done    unit completion pulse
//   unit_theta   unit result, valid with unit_done
// ---------------------------------------------------------------------------
module asin_unit_scheduler #(
    parameter int NREQ    = 4,
    parameter int XW      = 16,
    parameter int TW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*XW-1:0] req_x,
    output logic [NREQ-1:0]    ack,
    output logic               resp_valid,
    output logic [2:0]         resp_id,
    output logic [TW-1:0]      resp_theta,
    output logic               resp_err,
    output logic               unit_start,
    output logic [XW-1:0]      unit_x,
    input  logic               unit_done,
    input  logic [TW-1:0]      unit_theta
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    // +1.0 and -1.0 in Q2.14, the inclusive bounds of the arcsine domain.
    localparam logic signed [XW-1:0] X_POS_ONE = {2'b01, {(XW-2){1'b0}}};
    localparam logic signed [XW-1:0] X_NEG_ONE = {2'b11, {(XW-2){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   r_g;
    logic [XW-1:0]   r_x;
    logic            r_dom_err;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_resp_id;
    logic [TW-1:0]   r_resp_theta;
    logic            r_resp_err;

    logic [XW-1:0]   w_xs [NREQ];
    logic [IW:0]     w_scan;
    logic            w_found;
    logic [IW-1:0]   w_idx;
    logic [XW-1:0]   w_x;
    logic            w_dom;
    logic [IW-1:0]   w_rr_next;
    logic            w_timeout;
    logic [NREQ-1:0] w_ack_vec;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_split
        assign w_xs[gi] = req_x[gi*XW +: XW];
    end

    // Round-robin scan: walk NREQ positions starting at r_rr_ptr, wrapping,
    // and keep the first requester found.
    // NOTE: every combinational output gets a default before any branch so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_scan  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (IW+1)'(k);
            if (w_scan >= (IW+1)'(NREQ)) begin
                w_scan = w_scan - (IW+1)'(NREQ);
            end
            if (!w_found && req_valid[w_scan[IW-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_scan[IW-1:0];
            end
        end
    end

    assign w_x       = w_xs[w_idx];
    assign w_dom     = ($signed(w_x) > X_POS_ONE) || ($signed(w_x) < X_NEG_ONE);
    assign w_rr_next = (w_idx == IW'(NREQ-1)) ? '0 : w_idx + 1'b1;
    assign w_timeout = (r_cnt == CW'(TIMEOUT-1));
    assign w_ack_vec = {{(NREQ-1){1'b0}}, 1'b1} << r_g;

    // NOTE: state and datapath registers use non-blocking assignments so
    // every flop samples the values from before the clock edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        ack        = '0;
        unit_start = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = w_dom ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                unit_start = 1'b1;
                ack        = w_ack_vec;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (unit_done || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                // A rejected argument is acknowledged together with its error.
                if (r_dom_err) begin
                    ack = w_ack_vec;
                end
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The resp_* registers load only on the way into RESP, so they show the
    // new result during the strobe and hold it until the next one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rr_ptr     <= '0;
            r_g          <= '0;
            r_x          <= '0;
            r_dom_err    <= 1'b0;
            r_cnt        <= '0;
            r_resp_id    <= '0;
            r_resp_theta <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_g       <= w_idx;
                        r_x       <= w_x;
                        r_dom_err <= w_dom;
                        r_rr_ptr  <= w_rr_next;
                        if (w_dom) begin
                            r_resp_id    <= 3'(w_idx);
                            r_resp_theta <= '0;
                            r_resp_err   <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A completion in the timeout cycle still counts as success.
                    if (unit_done) begin
                        r_resp_id    <= 3'(r_g);
                        r_resp_theta <= unit_theta;
                        r_resp_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_resp_id    <= 3'(r_g);
                        r_resp_theta <= '0;
                        r_resp_err   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign unit_x     = r_x;
    assign resp_id    = r_resp_id;
    assign resp_theta = r_resp_theta;
    assign resp_err   = r_resp_err;

endmodule
